fp_rsqrt_seq: RTL and testbench
===============================

FP_RSQRT_SEQ -- requirements
Module: fp_rsqrt_seq

Interface
REQ-001 SHALL have parameter N_ITER, default 2 (legal 1..4): number of Newton-Raphson iterations.
REQ-002 SHALL have parameter MAGIC, default 32'h5F375A86: seed constant.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: operand offered.
REQ-006 SHALL have port in_ready, output, 1: operand accepted when high together with in_valid.
REQ-007 SHALL have port in_data, input, 32: IEEE-754 single operand x.
REQ-008 SHALL have port out_valid, output, 1: result available.
REQ-009 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-010 SHALL have port out_data, output, 32: IEEE-754 single result.
REQ-011 SHALL have port out_flags, output, 2: {invalid, div_by_zero}.

Function
REQ-012 SHALL use FSM states IDLE, SQ, MH, SUB, UPD, DONE; in_ready = (state == IDLE).
REQ-013 On handshake in IDLE: latch x and xh = x with exponent-1 (exact x/2); latch seed y = MAGIC - (x >> 1); go to SQ.
REQ-014 Per iteration, one operation per state: SQ yy = y*y; MH t = xh*yy; SUB h = 1.5 - t; UPD y = y*h, then increment the iteration counter.
REQ-015 UPD SHALL go to SQ if the counter < N_ITER, else to DONE; the counter clears on accept.
REQ-016 Normal operand latency: out_valid SHALL rise exactly 4*N_ITER+1 cycles after the handshake cycle.
REQ-017 Multiply: 24x24 mantissa product, normalise by 0/1 shift, truncate to 23 bits, exponent e1+e2-127 (+1 on shift); sign is XOR.
REQ-018 Subtract: align the smaller exponent, truncate shifted-out bits, normalise the leading one.
REQ-019 Special operands SHALL bypass iteration and go IDLE -> DONE (latency 1):
- +0, -0, or denormal (flushed to zero): out_data 32'h7F800000, flags 2'b01.
- Negative nonzero, or any NaN: out_data 32'h7FC00000, flags 2'b10.
- +inf: out_data 32'h00000000, flags 2'b00.
REQ-020 Normal operands SHALL produce out_flags 2'b00.
REQ-021 In DONE, out_valid SHALL be 1 and out_data/out_flags SHALL hold stable until out_ready; DONE with out_ready goes to IDLE.
REQ-022 No new operand SHALL be accepted in the DONE-exit cycle; the next accept is earliest the following cycle.
REQ-023 in_data changes after the accept cycle SHALL NOT affect the result.

Reset
REQ-024 rst_n low at a clock edge SHALL force state IDLE, out_valid 0, out_data 0, out_flags 0, counter 0, and clear all datapath registers.
REQ-025 Reset mid-operation SHALL discard the operation with no output; in_ready SHALL be 1 on the first cycle after reset release.

Configuration
REQ-026 Macro FP_RSQRT_RECIP_EN defined SHALL add input port op (1 bit, sampled at accept): 0 = rsqrt, 1 = reciprocal.
REQ-027 Reciprocal mode SHALL iterate on |x|, then run one extra state SQR (y*y) before DONE.
- Result sign = sign of x; latency 4*N_ITER+2.
- ±0 gives signed inf with flags 01; ±inf gives signed zero; NaN gives 32'h7FC00000 with flags 10.
REQ-028 Macro undefined: no op port, no SQR state, rsqrt-only behaviour as above.

Structure
REQ-029 Shared package fp_pkg SHALL hold constants FP_ONE_HALF 32'h3F000000, FP_THREE_HALFS 32'h3FC00000, FP_QNAN 32'h7FC00000, FP_POS_INF 32'h7F800000, and the FSM state enum.
REQ-030 One combinational sub-module fp_mul_core (a, b -> product) SHALL be instantiated exactly once and time-shared across SQ/MH/UPD/SQR via operand muxes.
REQ-031 The subtract in SUB SHALL be inline logic, not a separate multiplier or adder instance per state.

Verification
REQ-032 x = 32'h40800000 (4.0), N_ITER=2 -> out_data within 1e-5 relative of 0.5; out_valid exactly 9 cycles after accept; flags 00.
REQ-033 x = 32'h00000000, then x = 32'hBF800000 (-1.0) -> 32'h7F800000 flags 01, then 32'h7FC00000 flags 10; each with latency 1.
REQ-034 x = 32'h3F800000 (1.0), hold out_ready low 5 cycles in DONE -> out_data stable within 1e-5 relative of 1.0, in_ready low throughout, in_ready high the cycle after the pop.
REQ-035 Accept x = 32'h41100000 (9.0), pull rst_n low in state MH for 1 cycle -> no out_valid ever; in_ready 1 the next cycle; subsequent 9.0 gives ≈0.33333 within 1e-5.
REQ-036 With FP_RSQRT_RECIP_EN, op=1, x = 32'hC0000000 (-2.0), N_ITER=2 -> ≈ -0.5 (32'hBF000000 within 2e-5 relative), latency 10 cycles.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point constants and the rsqrt sequencer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;

    localparam logic [31:0] FP_ONE_HALF    = 32'h3F000000;
    localparam logic [31:0] FP_THREE_HALFS = 32'h3FC00000;
    localparam logic [31:0] FP_QNAN        = 32'h7FC00000;
    localparam logic [31:0] FP_POS_INF     = 32'h7F800000;

    // SQR only exists when the reciprocal mode is built in.
    typedef enum logic [2:0] {
        IDLE,
        SQ,
        MH,
        SUB,
        UPD,
        DONE
`ifdef FP_RSQRT_RECIP_EN
        ,
        SQR
`endif
    } state_t;

endpackage

// File: rtl/fp_mul_core.sv
// Combinational single-precision multiply of two normal operands (truncating).
// Latency: 0 cycles, pure combinational.
// Backpressure: none; the caller registers the product.
module fp_mul_core (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    logic [23:0]        ma;
    logic [23:0]        mb;
    logic [24:0]        hi;
    logic [22:0]        mant;
    logic signed [9:0]  e;
    logic               s;

    // 24x24 mantissa product, keep the top bits, 0/1 normalising shift, truncate
    always_comb begin
        ma   = {1'b1, a[22:0]};
        mb   = {1'b1, b[22:0]};
        hi   = 25'(({24'b0, ma} * {24'b0, mb}) >> 23);
        mant = hi[24] ? hi[23:1] : hi[22:0];
        s    = a[31] ^ b[31];
        e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]})
             - 10'sd127 + $signed({9'b0, hi[24]});
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 10'sd0) begin
            p = {s, 31'b0};
        end else if (e >= 10'sd255) begin
            p = {s, 8'hFF, 23'b0};
        end else begin
            p = {s, e[7:0], mant};
        end
    end

endmodule

// File: rtl/fp_rsqrt_seq.sv
// Sequential Newton-Raphson 1/sqrt(x) (optional 1/x with FP_RSQRT_RECIP_EN) on one shared multiplier.
// Latency: 4*N_ITER+1 cycles normal (+1 for reciprocal), 1 cycle for special operands.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module fp_rsqrt_seq
    import fp_pkg::*;
#(
    parameter int          N_ITER = 2,
    parameter logic [31:0] MAGIC  = 32'h5F375A86
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FP_RSQRT_RECIP_EN
    input  logic        op,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_flags
);

    localparam logic [2:0] N_ITER_L = 3'(N_ITER);

    state_t       state_q, state_d;
    logic [31:0]  xh_q, y_q, tmp_q, out_data_q;
    logic [1:0]   out_flags_q;
    logic [2:0]   iter_q, iter_inc;
`ifdef FP_RSQRT_RECIP_EN
    logic         recip_q, sign_q;
`endif

    logic         accept;
    logic         is_zero, is_nan, is_inf;
    logic         spec_hit;
    logic [31:0]  spec_dat;
    logic [1:0]   spec_flg;
    logic [31:0]  seed, xh;
    logic [31:0]  mul_a, mul_b, mul_p;
    logic [31:0]  sub_res;

    assign accept   = in_valid && in_ready;
    assign iter_inc = iter_q + 3'd1;

    // Classify the offered operand; specials skip the iteration entirely
    always_comb begin
        is_zero  = (in_data[30:23] == 8'd0);
        is_nan   = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
        is_inf   = (in_data[30:23] == 8'hFF) && (in_data[22:0] == 23'd0);
        spec_hit = 1'b0;
        spec_dat = 32'd0;
        spec_flg = 2'b00;
        if (is_zero) begin
            spec_hit = 1'b1; spec_dat = FP_POS_INF; spec_flg = 2'b01;
        end else if (is_nan || in_data[31]) begin
            spec_hit = 1'b1; spec_dat = FP_QNAN;    spec_flg = 2'b10;
        end else if (is_inf) begin
            spec_hit = 1'b1; spec_dat = 32'd0;      spec_flg = 2'b00;
        end
`ifdef FP_RSQRT_RECIP_EN
        // Reciprocal accepts negatives; zero and inf keep the operand sign
        if (op) begin
            spec_hit = is_zero || is_nan || is_inf;
            spec_flg = 2'b00;
            spec_dat = {in_data[31], 31'b0};
            if (is_zero) begin
                spec_dat = {in_data[31], FP_POS_INF[30:0]}; spec_flg = 2'b01;
            end else if (is_nan) begin
                spec_dat = FP_QNAN;                         spec_flg = 2'b10;
            end
        end
`endif
        // Iteration always runs on |x|, so the sign bit is dropped here
        seed = MAGIC - {2'b00, in_data[30:1]};
        xh   = {1'b0, in_data[30:23] - 8'd1, in_data[22:0]};
    end

    // Steer the shared multiplier for the current step
    always_comb begin
        mul_a = y_q;
        mul_b = y_q;
        case (state_q)
            MH:      begin mul_a = xh_q; mul_b = tmp_q; end
            UPD:     begin mul_a = y_q;  mul_b = tmp_q; end
            default: begin mul_a = y_q;  mul_b = y_q;   end
        endcase
    end

    fp_mul_core u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    logic [7:0]        sa_e, sb_e, big_e, sml_e, dexp;
    logic [23:0]       sa_m, sb_m, big_m, sml_m, sml_sh, dif;
    logic [22:0]       norm;
    logic [4:0]        lz;
    logic              lz_found, swap;
    logic signed [9:0] res_e;

    // h = 1.5 - t: align smaller operand (truncating), subtract, renormalise
    always_comb begin
        sa_e   = FP_THREE_HALFS[30:23];
        sa_m   = {1'b1, FP_THREE_HALFS[22:0]};
        sb_e   = tmp_q[30:23];
        sb_m   = {1'b1, tmp_q[22:0]};
        swap   = {sb_e, sb_m} > {sa_e, sa_m};
        big_e  = swap ? sb_e : sa_e;
        big_m  = swap ? sb_m : sa_m;
        sml_e  = swap ? sa_e : sb_e;
        sml_m  = swap ? sa_m : sb_m;
        dexp   = big_e - sml_e;
        sml_sh = (dexp > 8'd23) ? 24'd0 : (sml_m >> dexp);
        dif    = big_m - sml_sh;
        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lz_found && dif[i]) begin
                lz       = 5'(23 - i);
                lz_found = 1'b1;
            end
        end
        norm  = 23'(dif << lz);
        res_e = $signed({2'b00, big_e}) - $signed({5'b0, lz});
        if (sb_e == 8'd0) begin
            sub_res = FP_THREE_HALFS;
        end else if (dif == 24'd0 || res_e <= 10'sd0) begin
            sub_res = 32'd0;
        end else begin
            sub_res = {swap, res_e[7:0], norm};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: four steps per iteration, specials jump straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = spec_hit ? DONE : SQ;
            SQ:   state_d = MH;
            MH:   state_d = SUB;
            SUB:  state_d = UPD;
            UPD: begin
                if (iter_inc < N_ITER_L)  state_d = SQ;
`ifdef FP_RSQRT_RECIP_EN
                else if (recip_q)         state_d = SQR;
`endif
                else                      state_d = DONE;
            end
`ifdef FP_RSQRT_RECIP_EN
            SQR:  state_d = DONE;
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: operand latch, per-step results, held output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xh_q        <= 32'd0;
            y_q         <= 32'd0;
            tmp_q       <= 32'd0;
            iter_q      <= 3'd0;
            out_data_q  <= 32'd0;
            out_flags_q <= 2'b00;
`ifdef FP_RSQRT_RECIP_EN
            recip_q     <= 1'b0;
            sign_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    xh_q   <= xh;
                    y_q    <= seed;
                    tmp_q  <= 32'd0;
                    iter_q <= 3'd0;
`ifdef FP_RSQRT_RECIP_EN
                    recip_q <= op;
                    sign_q  <= in_data[31];
`endif
                    if (spec_hit) begin
                        out_data_q  <= spec_dat;
                        out_flags_q <= spec_flg;
                    end
                end
                SQ, MH: tmp_q <= mul_p;
                SUB:    tmp_q <= sub_res;
                UPD: begin
                    y_q    <= mul_p;
                    iter_q <= iter_inc;
                    if (state_d == DONE) begin
                        out_data_q  <= mul_p;
                        out_flags_q <= 2'b00;
                    end
                end
`ifdef FP_RSQRT_RECIP_EN
                SQR: begin
                    out_data_q  <= {sign_q, mul_p[30:0]};
                    out_flags_q <= 2'b00;
                end
`endif
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and the held result
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_data  = out_data_q;
        out_flags = out_flags_q;
    end

endmodule

// File: tb/tb_fp_rsqrt_seq.sv
// Bench for fp_rsqrt_seq: directed cases plus random operands against a real-valued Newton model.
// Latency: checks accept-to-valid cycle counts.
// Backpressure: holds out_ready low for random spans in DONE.
module tb_fp_rsqrt_seq;
    import fp_pkg::*;

    localparam int          N_ITER = 2;
    localparam logic [31:0] MAGIC  = 32'h5F375A86;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_flags;
`ifdef FP_RSQRT_RECIP_EN
    logic        op_s;
`endif

    int n_vec = 0;
    int n_err = 0;

    fp_rsqrt_seq #(.N_ITER(N_ITER), .MAGIC(MAGIC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef FP_RSQRT_RECIP_EN
        .op        (op_s),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp, input int tol);
        logic [31:0] d;
        d = (got > exp) ? got - exp : exp - got;
        n_vec++;
        if (d > 32'(tol)) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic real b2r(input logic [31:0] b);
        real m;
        int  e;
        m = 1.0 + real'(b & 32'h007F_FFFF) / 8388608.0;
        e = int'((b >> 23) & 32'hFF) - 127;
        return (b[31] ? -1.0 : 1.0) * m * (2.0 ** e);
    endfunction

    function automatic logic [31:0] r2b(input real v_in);
        real v;
        int  e;
        logic s;
        s = (v_in < 0.0);
        v = s ? -v_in : v_in;
        e = 127;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((v - 1.0) * 8388608.0))};
    endfunction

    // Allowed ulp distance for a given relative error around value b
    function automatic int rtol(input logic [31:0] b, input real rel);
        return $rtoi(rel * 8388608.0 * (1.0 + real'(b & 32'h007F_FFFF) / 8388608.0));
    endfunction

    // Reference: classify, else seed from bits and run N_ITER ideal Newton steps
    task automatic ref_model(input logic [31:0] x, output logic [31:0] d, output logic [1:0] f,
                             output int lat, output int tol);
        real xr, y;
        logic [31:0] sd;
        tol = 0;
        lat = 1;
        if (((x >> 23) & 32'hFF) == 32'd0) begin
            d = FP_POS_INF; f = 2'b01;
        end else if (((x >> 23) & 32'hFF) == 32'hFF && (x & 32'h7FFFFF) != 32'd0) begin
            d = FP_QNAN; f = 2'b10;
        end else if (x[31]) begin
            d = FP_QNAN; f = 2'b10;
        end else if (((x >> 23) & 32'hFF) == 32'hFF) begin
            d = 32'd0; f = 2'b00;
        end else begin
            xr = b2r(x);
            sd = MAGIC - (x >> 1);
            y  = b2r(sd);
            for (int i = 0; i < N_ITER; i++) y = y * (1.5 - 0.5 * xr * y * y);
            d   = r2b(y);
            f   = 2'b00;
            lat = 4 * N_ITER + 1;
            tol = 16;
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] exp_d, input logic [1:0] exp_f,
                          input int exp_lat, input int tol, input int hold);
        int w;
        int lat;
        in_data  = x;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        chk("ready_before_accept", 32'(in_ready), 32'd1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 1;
        while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        chk("latency", 32'(lat), 32'(exp_lat), 0);
        chk("data_first", out_data, exp_d, tol);
        for (int h = 0; h < hold; h++) begin
            chk("ready_low_in_done", 32'(in_ready), 32'd0, 0);
            @(posedge clk); #1;
            chk("valid_held", 32'(out_valid), 32'd1, 0);
        end
        chk("data", out_data, exp_d, tol);
        chk("flags", 32'(out_flags), 32'(exp_f), 0);
        chk("ready_low_at_pop", 32'(in_ready), 32'd0, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ready_after_pop", 32'(in_ready), 32'd1, 0);
        chk("valid_after_pop", 32'(out_valid), 32'd0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] x, ed;
        logic [1:0]  ef;
        int          el, et, cls;
        bit          seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'hDEADBEEF;
        out_ready = 1'b0;
`ifdef FP_RSQRT_RECIP_EN
        op_s      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(out_valid), 32'd0, 0);
        chk("reset_data", out_data, 32'd0, 0);
        chk("reset_flags", 32'(out_flags), 32'd0, 0);
        chk("reset_ready", 32'(in_ready), 32'd1, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(32'h40800000, FP_ONE_HALF, 2'b00, 4 * N_ITER + 1, rtol(FP_ONE_HALF, 1e-5), 0);
        run_op(32'h00000000, FP_POS_INF, 2'b01, 1, 0, 0);
        run_op(32'hBF800000, FP_QNAN, 2'b10, 1, 0, 0);
        run_op(32'h3F800000, 32'h3F800000, 2'b00, 4 * N_ITER + 1, rtol(32'h3F800000, 1e-5), 5);
        run_op(32'h7F800000, 32'h00000000, 2'b00, 1, 0, 1);
        run_op(32'h7FC01234, FP_QNAN, 2'b10, 1, 0, 0);

        // Reset while the operation sits in MH discards it
        in_data  = 32'h41100000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ready_after_reset", 32'(in_ready), 32'd1, 0);
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            seen = seen | out_valid;
            @(posedge clk); #1;
        end
        chk("no_output_after_reset", 32'(seen), 32'd0, 0);
        run_op(32'h41100000, 32'h3EAAAAAB, 2'b00, 4 * N_ITER + 1, rtol(32'h3EAAAAAB, 1e-5), 0);

`ifdef FP_RSQRT_RECIP_EN
        op_s = 1'b1;
        run_op(32'hC0000000, 32'hBF000000, 2'b00, 4 * N_ITER + 2, rtol(32'hBF000000, 2e-5), 0);
        run_op(32'h80000000, 32'hFF800000, 2'b01, 1, 0, 0);
        run_op(32'hFF800000, 32'h80000000, 2'b00, 1, 0, 0);
        op_s = 1'b0;
`endif

        // Random operands, mostly normal positives with specials mixed in
        for (int k = 0; k < 60; k++) begin
            cls = $urandom_range(0, 9);
            x   = $urandom;
            case (cls)
                0: x = {x[31], 8'h00, x[22:0]};
                1: x = {x[31], 8'hFF, x[22:1], 1'b1};
                2: x = {x[31], 8'hFF, 23'd0};
                3: x = {1'b1, 8'($urandom_range(20, 230)), x[22:0]};
                default: x = {1'b0, 8'($urandom_range(20, 230)), x[22:0]};
            endcase
            ref_model(x, ed, ef, el, et);
            run_op(x, ed, ef, el, et, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
